// File: rtl/alu_pkg.sv
// Shared constants for the ALU request sequencer: ALU control codes, ALUOp and
// funct encodings, and the sequencer FSM state type.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and response channels of the ALU sequencer. The master side is the
// requester/consumer; the slave side is the sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        aluop;
    logic [5:0]        funct;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req_valid, aluop, funct, src1, src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, aluop, funct, src1, src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of ALUOp/funct into the 4-bit ALU control code.
// Unknown R-type funct values raise illegal_o; code_o is then a don't-care.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] code_o,
    output logic       illegal_o
);

    // ALUOp / funct to control-code mapping
    always_comb begin
        code_o    = ALU_AND;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: code_o = ALU_ADD;
            ALUOP_SUB: code_o = ALU_SUB;
            ALUOP_SLT: code_o = ALU_SLT;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: code_o = ALU_ADD;
                    FUNCT_SUB: code_o = ALU_SUB;
                    FUNCT_AND: code_o = ALU_AND;
                    FUNCT_OR:  code_o = ALU_OR;
                    FUNCT_SLT: code_o = ALU_SLT;
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request-side driver for the combinational ALU: accepts one operation, holds
// the ALU inputs for a cycle, captures result/zero and returns them.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_op_sequencer_if.slave   bus,
    output logic [DATA_W-1:0]   alu_src1_o,
    output logic [DATA_W-1:0]   alu_src2_o,
    output logic [3:0]          alu_ctrl_o,
    input  logic [DATA_W-1:0]   alu_result_i,
    input  logic                alu_zero_i
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [3:0]        dec_code_s;
    logic              dec_illegal_s;
    logic              req_ready_s;
    logic              accept_s;

    alu_op_decode u_decode (
        .aluop_i   (bus.aluop),
        .funct_i   (bus.funct),
        .code_o    (dec_code_s),
        .illegal_o (dec_illegal_s)
    );

    assign req_ready_s = (state_q == ST_IDLE) && !rst_i;
    assign accept_s    = req_ready_s && bus.req_valid;

    // Next-state logic; an illegal funct skips EXEC and leaves ctrl untouched
    always_comb begin
        state_d     = state_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        ctrl_d      = ctrl_q;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    src1_d   = bus.src1;
                    src2_d   = bus.src2;
                    result_d = '0;
                    zero_d   = 1'b0;
                    err_d    = dec_illegal_s;
                    if (dec_illegal_s) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        ctrl_d  = dec_code_s;
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_d    = alu_result_i;
                zero_d      = alu_zero_i;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            src1_q      <= '0;
            src2_q      <= '0;
            ctrl_q      <= 4'b0000;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            ctrl_q      <= ctrl_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    assign alu_src1_o     = src1_q;
    assign alu_src2_o     = src2_q;
    assign alu_ctrl_o     = ctrl_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU closing the loop
// between alu_*_o and alu_*_i.
module tb_alu_op_sequencer;

    localparam int DW = 32;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_src1, alu_src2, alu_result;
    logic [3:0]    alu_ctrl;
    logic          alu_zero;

    alu_op_sequencer_if #(.DATA_W(DW)) bus ();

    alu_op_sequencer #(.DATA_W(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .alu_src1_o   (alu_src1),
        .alu_src2_o   (alu_src2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: alu_result = alu_src1 + alu_src2;
            4'b0110: alu_result = alu_src1 - alu_src2;
            4'b0111: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    int   n_cmp = 0;
    int   n_mis = 0;
    int   neg_cnt = 0;
    int   rsp_cnt = 0;
    exp_t sb[$];
    logic [3:0] last_ctrl = 4'b0000;
    vec_t vecs[12];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each new response, checks stability while stalled
    initial begin
        logic prev_valid;
        exp_t cur;
        prev_valid = 1'b0;
        cur = '{4'b0000, 32'd0, 1'b0, 1'b0, 0, 0};
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.rsp_valid) begin
                    if (!prev_valid) begin
                        check_eq("rsp_expected", 64'(sb.size()), 64'd1);
                        if (sb.size() > 0) begin
                            cur = sb.pop_front();
                            check_eq("alu_ctrl", 64'(alu_ctrl), 64'(cur.ctrl));
                            check_eq("rsp_result", 64'(bus.rsp_result), 64'(cur.res));
                            check_eq("rsp_zero", 64'(bus.rsp_zero), 64'(cur.zero));
                            check_eq("rsp_err", 64'(bus.rsp_err), 64'(cur.err));
                            check_eq("latency", 64'(neg_cnt - cur.acc), 64'(cur.lat));
                        end
                    end else begin
                        check_eq("stall_result", 64'(bus.rsp_result), 64'(cur.res));
                        check_eq("stall_zero", 64'(bus.rsp_zero), 64'(cur.zero));
                        check_eq("stall_err", 64'(bus.rsp_err), 64'(cur.err));
                    end
                    check_eq("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
                    if (bus.rsp_ready) rsp_cnt++;
                end
                prev_valid = bus.rsp_valid;
            end
        end
    end

    task automatic send(input vec_t v);
        exp_t e;
        for (int k = 0; k < 20 && !bus.req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("req_ready_before_send", 64'(bus.req_ready), 64'd1);
        bus.aluop     = v.aluop;
        bus.funct     = v.funct;
        bus.src1      = v.a;
        bus.src2      = v.b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        e.ctrl = v.err ? last_ctrl : v.ctrl;
        if (!v.err) last_ctrl = v.ctrl;
        e.res  = v.res;
        e.zero = v.zero;
        e.err  = v.err;
        e.lat  = v.err ? 1 : 2;
        e.acc  = neg_cnt;
        sb.push_back(e);
        #1;
        bus.req_valid = 1'b0;
        bus.aluop     = 2'($urandom);
        bus.funct     = 6'($urandom);
        bus.src1      = $urandom;
        bus.src2      = $urandom;
        check_eq("req_ready_after_accept", 64'(bus.req_ready), 64'd0);
    endtask

    task automatic wait_rsp(input int start);
        for (int k = 0; k < 30 && rsp_cnt <= start; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("rsp_handshake", 64'(rsp_cnt > start), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
        check_eq({tag, "_rsp_zero"}, 64'(bus.rsp_zero), 64'd0);
        check_eq({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check_eq({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
        check_eq({tag, "_alu_src1"}, 64'(alu_src1), 64'd0);
        check_eq({tag, "_alu_src2"}, 64'(alu_src2), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   start;
        vec_t v;
        vecs[0]  = '{2'b10, 6'b100000, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'h0000_1234,  32'h0000_1234,  4'b0110, 32'd0,          1'b1, 1'b0};
        vecs[2]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd1,          1'b0, 1'b0};
        vecs[3]  = '{2'b10, 6'b000111, 32'd9,          32'd9,          4'b0000, 32'd0,          1'b0, 1'b1};
        vecs[4]  = '{2'b00, 6'b000111, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b1, 1'b0};
        vecs[5]  = '{2'b11, 6'b000000, 32'd3,          32'd5,          4'b0111, 32'd1,          1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'b100100, 32'hF0F0_F0F0,  32'hFF00_FF00,  4'b0000, 32'hF000_F000,  1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b100101, 32'h0F0F_0000,  32'h0000_00F0,  4'b0001, 32'h0F0F_00F0,  1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b100010, 32'd10,         32'd3,          4'b0110, 32'd7,          1'b0, 1'b0};
        vecs[9]  = '{2'b11, 6'b111111, 32'd5,          32'd3,          4'b0111, 32'd0,          1'b1, 1'b0};
        vecs[10] = '{2'b10, 6'b111111, 32'd1,          32'd2,          4'b0000, 32'd0,          1'b0, 1'b1};
        vecs[11] = '{2'b01, 6'b000000, 32'd3,          32'd5,          4'b0110, 32'hFFFF_FFFE,  1'b0, 1'b0};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.aluop     = 2'b00;
        bus.funct     = 6'b000000;
        bus.src1      = 32'd0;
        bus.src2      = 32'd0;
        bus.rsp_ready = 1'b1;
        #12;
        check_all_zero("reset");
        check_eq("reset_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_reset_req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            start = rsp_cnt;
            send(vecs[i]);
            wait_rsp(start);
        end

        // response stall with competing requests
        bus.rsp_ready = 1'b0;
        start = rsp_cnt;
        v = '{2'b10, 6'b100000, 32'h0000_0100, 32'h0000_0200, 4'b0010, 32'h0000_0300, 1'b0, 1'b0};
        send(v);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.aluop     = 2'b00;
            bus.src1      = $urandom;
            check_eq("stall_req_ready", 64'(bus.req_ready), 64'd0);
        end
        check_eq("stall_no_handshake", 64'(rsp_cnt), 64'(start));
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_rsp(start);

        // reset while in EXEC drops the operation
        start = rsp_cnt;
        v = '{2'b01, 6'b000000, 32'd9, 32'd4, 4'b0110, 32'd5, 1'b0, 1'b0};
        send(v);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        check_eq("mid_reset_req_ready", 64'(bus.req_ready), 64'd0);
        sb.delete();
        last_ctrl = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("no_rsp_after_reset", 64'(rsp_cnt), 64'(start));
        check_eq("idle_after_reset", 64'(bus.req_ready), 64'd1);
        check_eq("valid_after_reset", 64'(bus.rsp_valid), 64'd0);

        start = rsp_cnt;
        v = '{2'b00, 6'b000000, 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0, 1'b0};
        send(v);
        wait_rsp(start);
        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
